// File: rtl/cpu_bus_access.sv
// Two-port to one-port bus arbiter: port A (instruction fetch, read-only) and
// port B (data load/store) are serialised onto a single request/ready system bus.
module cpu_bus_access (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata,
    input  logic        i_pa_request,
    output logic        o_pa_ready,
    input  logic [31:0] i_pa_address,
    output logic [31:0] o_pa_rdata,
    input  logic        i_pb_rw,
    input  logic        i_pb_request,
    output logic        o_pb_ready,
    input  logic [31:0] i_pb_address,
    output logic [31:0] o_pb_rdata,
    input  logic [31:0] i_pb_wdata
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUS_A  = 3'd1,
        ST_BUS_B  = 3'd2,
        ST_WAIT_A = 3'd3,
        ST_WAIT_B = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_bus_rw;
    logic        r_bus_request;
    logic [31:0] r_bus_address;
    logic [31:0] r_bus_wdata;
    logic        r_pa_ready;
    logic [31:0] r_pa_rdata;
    logic        r_pb_ready;
    logic [31:0] r_pb_rdata;

    logic        w_bus_rw_next;
    logic        w_bus_request_next;
    logic [31:0] w_bus_address_next;
    logic [31:0] w_bus_wdata_next;
    logic        w_pa_ready_next;
    logic [31:0] w_pa_rdata_next;
    logic        w_pb_ready_next;
    logic [31:0] w_pb_rdata_next;

    // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        w_state_next       = r_state;
        w_bus_rw_next      = r_bus_rw;
        w_bus_request_next = r_bus_request;
        w_bus_address_next = r_bus_address;
        w_bus_wdata_next   = r_bus_wdata;
        w_pa_ready_next    = r_pa_ready;
        w_pa_rdata_next    = r_pa_rdata;
        w_pb_ready_next    = r_pb_ready;
        w_pb_rdata_next    = r_pb_rdata;

        case (r_state)
            ST_IDLE: begin
                // A ready still high here belongs to a slave finishing up; start nothing until it drops.
                if (!i_bus_ready) begin
                    if (i_pb_request) begin
                        w_bus_rw_next      = i_pb_rw;
                        w_bus_address_next = i_pb_address;
                        w_bus_wdata_next   = i_pb_wdata;
                        w_bus_request_next = 1'b1;
                        w_state_next       = ST_BUS_B;
                    end else if (i_pa_request) begin
                        w_bus_rw_next      = 1'b0;
                        w_bus_address_next = i_pa_address;
                        w_bus_wdata_next   = 32'h0;
                        w_bus_request_next = 1'b1;
                        w_state_next       = ST_BUS_A;
                    end
                end
            end

            ST_BUS_A: begin
                if (i_bus_ready) begin
                    w_bus_request_next = 1'b0;
                    w_pa_ready_next    = 1'b1;
                    w_pa_rdata_next    = i_bus_rdata;
                    w_state_next       = ST_WAIT_A;
                end
            end

            ST_BUS_B: begin
                if (i_bus_ready) begin
                    w_bus_request_next = 1'b0;
                    w_pb_ready_next    = 1'b1;
                    if (!r_bus_rw) begin
                        w_pb_rdata_next = i_bus_rdata;
                    end
                    w_state_next       = ST_WAIT_B;
                end
            end

            // Stay here until the requester lets go, so a held request is not issued twice.
            ST_WAIT_A: begin
                w_pa_ready_next = 1'b0;
                if (!i_pa_request) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_WAIT_B: begin
                w_pb_ready_next = 1'b0;
                if (!i_pb_request) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_bus_request_next = 1'b0;
                w_pa_ready_next    = 1'b0;
                w_pb_ready_next    = 1'b0;
                w_state_next       = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    // NOTE: the data registers are reset too, because every output, read data included, must read 0 in reset.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= ST_IDLE;
            r_bus_rw      <= 1'b0;
            r_bus_request <= 1'b0;
            r_bus_address <= 32'h0;
            r_bus_wdata   <= 32'h0;
            r_pa_ready    <= 1'b0;
            r_pa_rdata    <= 32'h0;
            r_pb_ready    <= 1'b0;
            r_pb_rdata    <= 32'h0;
        end else begin
            r_state       <= w_state_next;
            r_bus_rw      <= w_bus_rw_next;
            r_bus_request <= w_bus_request_next;
            r_bus_address <= w_bus_address_next;
            r_bus_wdata   <= w_bus_wdata_next;
            r_pa_ready    <= w_pa_ready_next;
            r_pa_rdata    <= w_pa_rdata_next;
            r_pb_ready    <= w_pb_ready_next;
            r_pb_rdata    <= w_pb_rdata_next;
        end
    end

    assign o_bus_rw      = r_bus_rw;
    assign o_bus_request = r_bus_request;
    assign o_bus_address = r_bus_address;
    assign o_bus_wdata   = r_bus_wdata;
    assign o_pa_ready    = r_pa_ready;
    assign o_pa_rdata    = r_pa_rdata;
    assign o_pb_ready    = r_pb_ready;
    assign o_pb_rdata    = r_pb_rdata;

    // Structural invariants of the arbiter; ignored by synthesis.
    a_request_in_bus_state: assert property (@(posedge i_clock) disable iff (!i_reset)
        r_bus_request == (r_state == ST_BUS_A || r_state == ST_BUS_B));

    a_ready_exclusive: assert property (@(posedge i_clock) disable iff (!i_reset)
        !(r_pa_ready && r_pb_ready));

    a_pa_ready_pulse: assert property (@(posedge i_clock) disable iff (!i_reset)
        r_pa_ready |=> !r_pa_ready);

    a_pb_ready_pulse: assert property (@(posedge i_clock) disable iff (!i_reset)
        r_pb_ready |=> !r_pb_ready);

    a_port_a_read_only: assert property (@(posedge i_clock) disable iff (!i_reset)
        (r_state == ST_BUS_A) |-> (!r_bus_rw && r_bus_wdata == 32'h0));

endmodule

// File: tb/tb_cpu_bus_access.sv
// Self-checking bench for cpu_bus_access: directed scenarios plus randomized
// two-port traffic checked against a transaction-order reference model.
module tb_cpu_bus_access;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        o_bus_rw;
    logic        o_bus_request;
    logic        i_bus_ready = 1'b0;
    logic [31:0] o_bus_address;
    logic [31:0] i_bus_rdata = 32'h0;
    logic [31:0] o_bus_wdata;
    logic        i_pa_request = 1'b0;
    logic        o_pa_ready;
    logic [31:0] i_pa_address = 32'h0;
    logic [31:0] o_pa_rdata;
    logic        i_pb_rw = 1'b0;
    logic        i_pb_request = 1'b0;
    logic        o_pb_ready;
    logic [31:0] i_pb_address = 32'h0;
    logic [31:0] o_pb_rdata;
    logic [31:0] i_pb_wdata = 32'h0;

    cpu_bus_access dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .o_bus_rw      (o_bus_rw),
        .o_bus_request (o_bus_request),
        .i_bus_ready   (i_bus_ready),
        .o_bus_address (o_bus_address),
        .i_bus_rdata   (i_bus_rdata),
        .o_bus_wdata   (o_bus_wdata),
        .i_pa_request  (i_pa_request),
        .o_pa_ready    (o_pa_ready),
        .i_pa_address  (i_pa_address),
        .o_pa_rdata    (o_pa_rdata),
        .i_pb_rw       (i_pb_rw),
        .i_pb_request  (i_pb_request),
        .o_pb_ready    (o_pb_ready),
        .i_pb_address  (i_pb_address),
        .o_pb_rdata    (o_pb_rdata),
        .i_pb_wdata    (i_pb_wdata)
    );

    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic        is_b;
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
    } txn_t;

    int n_checks = 0;
    int n_errors = 0;

    // Completed bus transactions and ready pulses, counted at the clock edge that consumes them.
    int bus_txn_count  = 0;
    int pa_pulse_count = 0;
    int pb_pulse_count = 0;

    // Reference model: last value each port's read data must hold.
    logic [31:0] exp_pa_rdata = 32'h0;
    logic [31:0] exp_pb_rdata = 32'h0;

    txn_t exp_q[$];

    always @(posedge i_clock) begin
        if (o_bus_request && i_bus_ready) bus_txn_count++;
        if (o_pa_ready) pa_pulse_count++;
        if (o_pb_ready) pb_pulse_count++;
    end

    task automatic tick();
        @(negedge i_clock);
    endtask

    task automatic clear_inputs();
        i_bus_ready  = 1'b0;
        i_bus_rdata  = 32'h0;
        i_pa_request = 1'b0;
        i_pa_address = 32'h0;
        i_pb_rw      = 1'b0;
        i_pb_request = 1'b0;
        i_pb_address = 32'h0;
        i_pb_wdata   = 32'h0;
    endtask

    task automatic test_reset();
        logic [133:0] outs;
        i_reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_bus_ready  = 1'($urandom);
            i_bus_rdata  = $urandom;
            i_pa_request = 1'($urandom);
            i_pa_address = $urandom;
            i_pb_rw      = 1'($urandom);
            i_pb_request = 1'($urandom);
            i_pb_address = $urandom;
            i_pb_wdata   = $urandom;
            tick();
            outs = {o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
                    o_pa_ready, o_pa_rdata, o_pb_ready, o_pb_rdata};
            n_checks++;
            if (outs !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs: got %h, expected all zero", outs);
            end
        end
        clear_inputs();
        i_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (o_bus_request !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_release_idle: o_bus_request=%b, expected 0", o_bus_request);
            end
        end
        exp_pa_rdata = 32'h0;
        exp_pb_rdata = 32'h0;
    endtask

    task automatic test_port_a_read();
        int base_txn = bus_txn_count;
        int base_pa  = pa_pulse_count;
        i_pa_address = 32'h0000_0100;
        i_pa_request = 1'b1;
        tick();
        n_checks++;
        if ({o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata} !== {1'b1, 1'b0, 32'h100, 32'h0}) begin
            n_errors++;
            $display("FAIL pa_issue: req=%b rw=%b addr=%h wdata=%h, expected 1 0 00000100 00000000",
                     o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata);
        end
        tick();
        tick();
        n_checks++;
        if ({o_bus_request, o_bus_address, o_pa_ready} !== {1'b1, 32'h100, 1'b0}) begin
            n_errors++;
            $display("FAIL pa_hold: req=%b addr=%h ready=%b, expected 1 00000100 0",
                     o_bus_request, o_bus_address, o_pa_ready);
        end
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'hDEAD_BEEF;
        tick();
        n_checks++;
        if ({o_pa_ready, o_pa_rdata, o_bus_request} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            n_errors++;
            $display("FAIL pa_complete: ready=%b rdata=%h req=%b, expected 1 deadbeef 0",
                     o_pa_ready, o_pa_rdata, o_bus_request);
        end
        i_bus_ready  = 1'b0;
        i_bus_rdata  = 32'h5555_AAAA;
        i_pa_request = 1'b0;
        tick();
        n_checks++;
        if ({o_pa_ready, o_pa_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
            n_errors++;
            $display("FAIL pa_pulse_end: ready=%b rdata=%h, expected 0 deadbeef", o_pa_ready, o_pa_rdata);
        end
        tick();
        tick();
        n_checks++;
        if (o_pa_rdata !== 32'hDEAD_BEEF || bus_txn_count != base_txn + 1 || pa_pulse_count != base_pa + 1) begin
            n_errors++;
            $display("FAIL pa_summary: rdata=%h txns=%0d pulses=%0d, expected deadbeef %0d %0d",
                     o_pa_rdata, bus_txn_count - base_txn, pa_pulse_count - base_pa, 1, 1);
        end
        exp_pa_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic test_port_b_write();
        int base_pb = pb_pulse_count;
        i_pb_rw      = 1'b1;
        i_pb_address = 32'h0001_0004;
        i_pb_wdata   = 32'h1234_5678;
        i_pb_request = 1'b1;
        tick();
        n_checks++;
        if ({o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata} !== {1'b1, 1'b1, 32'h0001_0004, 32'h1234_5678}) begin
            n_errors++;
            $display("FAIL pb_write_issue: req=%b rw=%b addr=%h wdata=%h, expected 1 1 00010004 12345678",
                     o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata);
        end
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'hCAFE_F00D;
        tick();
        n_checks++;
        if ({o_pb_ready, o_pb_rdata, o_bus_request} !== {1'b1, exp_pb_rdata, 1'b0}) begin
            n_errors++;
            $display("FAIL pb_write_complete: ready=%b rdata=%h req=%b, expected 1 %h 0",
                     o_pb_ready, o_pb_rdata, o_bus_request, exp_pb_rdata);
        end
        i_bus_ready  = 1'b0;
        i_pb_request = 1'b0;
        i_pb_rw      = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({o_pb_ready, o_pb_rdata} !== {1'b0, exp_pb_rdata} || pb_pulse_count != base_pb + 1) begin
            n_errors++;
            $display("FAIL pb_write_after: ready=%b rdata=%h pulses=%0d, expected 0 %h 1",
                     o_pb_ready, o_pb_rdata, pb_pulse_count - base_pb, exp_pb_rdata);
        end
    endtask

    task automatic test_simultaneous();
        int base_txn = bus_txn_count;
        int base_pa  = pa_pulse_count;
        int base_pb  = pb_pulse_count;
        logic [31:0] rd_b = $urandom;
        logic [31:0] rd_a = $urandom;
        i_pa_address = 32'h0000_0200;
        i_pb_address = 32'h2000_0000;
        i_pb_rw      = 1'b0;
        i_pa_request = 1'b1;
        i_pb_request = 1'b1;
        tick();
        n_checks++;
        if ({o_bus_request, o_bus_rw, o_bus_address} !== {1'b1, 1'b0, 32'h2000_0000}) begin
            n_errors++;
            $display("FAIL arb_b_first: req=%b rw=%b addr=%h, expected 1 0 20000000",
                     o_bus_request, o_bus_rw, o_bus_address);
        end
        i_bus_ready = 1'b1;
        i_bus_rdata = rd_b;
        tick();
        n_checks++;
        if ({o_pb_ready, o_pa_ready, o_pb_rdata} !== {1'b1, 1'b0, rd_b}) begin
            n_errors++;
            $display("FAIL arb_b_done: pb_ready=%b pa_ready=%b pb_rdata=%h, expected 1 0 %h",
                     o_pb_ready, o_pa_ready, o_pb_rdata, rd_b);
        end
        i_bus_ready  = 1'b0;
        i_pb_request = 1'b0;
        tick();
        n_checks++;
        if (o_bus_request !== 1'b0) begin
            n_errors++;
            $display("FAIL arb_gap: o_bus_request=%b, expected 0", o_bus_request);
        end
        tick();
        n_checks++;
        if ({o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata} !== {1'b1, 1'b0, 32'h200, 32'h0}) begin
            n_errors++;
            $display("FAIL arb_a_second: req=%b rw=%b addr=%h wdata=%h, expected 1 0 00000200 00000000",
                     o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata);
        end
        i_bus_ready = 1'b1;
        i_bus_rdata = rd_a;
        tick();
        n_checks++;
        if ({o_pa_ready, o_pa_rdata, o_pb_rdata} !== {1'b1, rd_a, rd_b}) begin
            n_errors++;
            $display("FAIL arb_a_done: ready=%b pa_rdata=%h pb_rdata=%h, expected 1 %h %h",
                     o_pa_ready, o_pa_rdata, o_pb_rdata, rd_a, rd_b);
        end
        i_bus_ready  = 1'b0;
        i_pa_request = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus_txn_count != base_txn + 2 || pa_pulse_count != base_pa + 1 || pb_pulse_count != base_pb + 1) begin
            n_errors++;
            $display("FAIL arb_counts: txns=%0d pa=%0d pb=%0d, expected 2 1 1",
                     bus_txn_count - base_txn, pa_pulse_count - base_pa, pb_pulse_count - base_pb);
        end
        exp_pa_rdata = rd_a;
        exp_pb_rdata = rd_b;
    endtask

    task automatic test_hold_after_ready();
        int base_txn = bus_txn_count;
        int base_pa  = pa_pulse_count;
        logic [31:0] rd = $urandom;
        i_pa_address = 32'h0000_0300;
        i_pa_request = 1'b1;
        tick();
        i_bus_ready = 1'b1;
        i_bus_rdata = rd;
        tick();
        n_checks++;
        if ({o_pa_ready, o_pa_rdata} !== {1'b1, rd}) begin
            n_errors++;
            $display("FAIL hold_zero_wait: ready=%b rdata=%h, expected 1 %h", o_pa_ready, o_pa_rdata, rd);
        end
        i_bus_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({o_bus_request, o_pa_ready} !== 2'b00) begin
                n_errors++;
                $display("FAIL hold_no_reissue: req=%b ready=%b, expected 0 0", o_bus_request, o_pa_ready);
            end
        end
        i_pa_request = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (o_bus_request !== 1'b0 || bus_txn_count != base_txn + 1 || pa_pulse_count != base_pa + 1) begin
            n_errors++;
            $display("FAIL hold_counts: req=%b txns=%0d pulses=%0d, expected 0 1 1",
                     o_bus_request, bus_txn_count - base_txn, pa_pulse_count - base_pa);
        end
        exp_pa_rdata = rd;
    endtask

    task automatic test_ready_outside_bus();
        int base_txn = bus_txn_count;
        logic [31:0] rd = $urandom;
        i_bus_ready = 1'b1;
        i_bus_rdata = $urandom;
        tick();
        tick();
        n_checks++;
        if ({o_bus_request, o_pa_ready, o_pb_ready, o_pa_rdata, o_pb_rdata} !== {3'b000, exp_pa_rdata, exp_pb_rdata}) begin
            n_errors++;
            $display("FAIL stray_ready: req=%b pa=%b pb=%b pa_rdata=%h pb_rdata=%h, expected 0 0 0 %h %h",
                     o_bus_request, o_pa_ready, o_pb_ready, o_pa_rdata, o_pb_rdata, exp_pa_rdata, exp_pb_rdata);
        end
        i_pa_address = 32'h0000_0400;
        i_pa_request = 1'b1;
        tick();
        n_checks++;
        if (o_bus_request !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_waits_ready_low: req=%b, expected 0", o_bus_request);
        end
        i_bus_ready = 1'b0;
        tick();
        n_checks++;
        if ({o_bus_request, o_bus_address} !== {1'b1, 32'h400}) begin
            n_errors++;
            $display("FAIL start_after_ready_low: req=%b addr=%h, expected 1 00000400", o_bus_request, o_bus_address);
        end
        i_bus_ready = 1'b1;
        i_bus_rdata = rd;
        tick();
        i_bus_ready  = 1'b0;
        i_pa_request = 1'b0;
        tick();
        tick();
        n_checks++;
        if (o_pa_rdata !== rd || bus_txn_count != base_txn + 1) begin
            n_errors++;
            $display("FAIL stray_ready_txn: rdata=%h txns=%0d, expected %h 1", o_pa_rdata, bus_txn_count - base_txn, rd);
        end
        exp_pa_rdata = rd;
    endtask

    task automatic test_random();
        logic        a_en, b_en, b_rw, b_first, in_txn;
        logic [31:0] a_addr, b_addr, b_wdata, rd;
        logic [64:0] cur, want;
        int          sa, sb, delay, hold_a, hold_b, dcnt, k;
        int          a_timer, b_timer, a_pulses, b_pulses, stable_err;
        for (int it = 0; it < 40; it++) begin
            a_en    = 1'($urandom_range(0, 1));
            b_en    = 1'($urandom_range(0, 1));
            if (!a_en && !b_en) a_en = 1'b1;
            a_addr  = $urandom;
            b_addr  = $urandom;
            b_rw    = 1'($urandom_range(0, 1));
            b_wdata = $urandom;
            sa      = int'($urandom_range(0, 3));
            sb      = int'($urandom_range(0, 3));
            delay   = int'($urandom_range(0, 3));
            hold_a  = int'($urandom_range(0, 3));
            hold_b  = int'($urandom_range(0, 3));

            // Expected bus order: B wins whenever it is pending no later than A.
            exp_q.delete();
            b_first = b_en && (!a_en || sb <= sa);
            if (b_first) begin
                exp_q.push_back('{is_b: 1'b1, addr: b_addr, rw: b_rw, wdata: b_wdata});
                if (a_en) exp_q.push_back('{is_b: 1'b0, addr: a_addr, rw: 1'b0, wdata: 32'h0});
            end else begin
                exp_q.push_back('{is_b: 1'b0, addr: a_addr, rw: 1'b0, wdata: 32'h0});
                if (b_en) exp_q.push_back('{is_b: 1'b1, addr: b_addr, rw: b_rw, wdata: b_wdata});
            end

            k = 0; in_txn = 1'b0; dcnt = 0; cur = '0;
            a_timer = -1; b_timer = -1; a_pulses = 0; b_pulses = 0; stable_err = 0;
            for (int cyc = 0; cyc < 40; cyc++) begin
                if (o_pa_ready) begin
                    a_pulses++;
                    a_timer = hold_a;
                    n_checks++;
                    if (o_pa_rdata !== exp_pa_rdata) begin
                        n_errors++;
                        $display("FAIL rand_pa_rdata it=%0d: got %h, expected %h", it, o_pa_rdata, exp_pa_rdata);
                    end
                end
                if (o_pb_ready) begin
                    b_pulses++;
                    b_timer = hold_b;
                    n_checks++;
                    if (o_pb_rdata !== exp_pb_rdata) begin
                        n_errors++;
                        $display("FAIL rand_pb_rdata it=%0d: got %h, expected %h", it, o_pb_rdata, exp_pb_rdata);
                    end
                end
                if (o_bus_request) begin
                    if (!in_txn) begin
                        in_txn = 1'b1;
                        dcnt   = 0;
                        cur    = {o_bus_address, o_bus_rw, o_bus_wdata};
                    end else if (cur !== {o_bus_address, o_bus_rw, o_bus_wdata}) begin
                        stable_err++;
                    end
                end

                if (o_bus_request && dcnt == delay) begin
                    rd          = $urandom;
                    i_bus_ready = 1'b1;
                    i_bus_rdata = rd;
                    in_txn      = 1'b0;
                    n_checks++;
                    if (k >= exp_q.size()) begin
                        n_errors++;
                        $display("FAIL rand_extra_txn it=%0d: bus txn %0d addr=%h, expected only %0d",
                                 it, k + 1, cur[64:33], exp_q.size());
                    end else begin
                        want = {exp_q[k].addr, exp_q[k].rw, exp_q[k].wdata};
                        if (cur !== want) begin
                            n_errors++;
                            $display("FAIL rand_txn it=%0d #%0d: got addr/rw/wdata %h, expected %h", it, k, cur, want);
                        end
                        if (!exp_q[k].rw) begin
                            if (exp_q[k].is_b) exp_pb_rdata = rd;
                            else               exp_pa_rdata = rd;
                        end
                    end
                    k++;
                end else begin
                    i_bus_ready = 1'b0;
                    i_bus_rdata = $urandom;
                    if (o_bus_request) dcnt++;
                end

                if (a_en && cyc == sa) begin
                    i_pa_address = a_addr;
                    i_pa_request = 1'b1;
                end
                if (b_en && cyc == sb) begin
                    i_pb_address = b_addr;
                    i_pb_rw      = b_rw;
                    i_pb_wdata   = b_wdata;
                    i_pb_request = 1'b1;
                end
                if (a_timer == 0) begin
                    i_pa_request = 1'b0;
                    a_timer = -1;
                end else if (a_timer > 0) begin
                    a_timer--;
                end
                if (b_timer == 0) begin
                    i_pb_request = 1'b0;
                    b_timer = -1;
                end else if (b_timer > 0) begin
                    b_timer--;
                end
                tick();
            end

            n_checks++;
            if (k != exp_q.size() || a_pulses != int'(a_en) || b_pulses != int'(b_en) || stable_err != 0) begin
                n_errors++;
                $display("FAIL rand_counts it=%0d: txns=%0d pa=%0d pb=%0d unstable=%0d, expected %0d %0d %0d 0",
                         it, k, a_pulses, b_pulses, stable_err, exp_q.size(), a_en, b_en);
            end
            n_checks++;
            if ({o_pa_rdata, o_pb_rdata, o_bus_request} !== {exp_pa_rdata, exp_pb_rdata, 1'b0}) begin
                n_errors++;
                $display("FAIL rand_final it=%0d: pa=%h pb=%h req=%b, expected %h %h 0",
                         it, o_pa_rdata, o_pb_rdata, o_bus_request, exp_pa_rdata, exp_pb_rdata);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_bus_b();
        logic [133:0] outs;
        int base_txn = bus_txn_count;
        i_pb_rw      = 1'b1;
        i_pb_address = 32'h0000_5000;
        i_pb_wdata   = $urandom;
        i_pb_request = 1'b1;
        tick();
        n_checks++;
        if (o_bus_request !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_setup: req=%b, expected 1", o_bus_request);
        end
        #2;
        i_reset = 1'b0;
        #1;
        outs = {o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
                o_pa_ready, o_pa_rdata, o_pb_ready, o_pb_rdata};
        n_checks++;
        if (outs !== '0) begin
            n_errors++;
            $display("FAIL midreset_async: outputs %h, expected all zero before any clock edge", outs);
        end
        clear_inputs();
        exp_pa_rdata = 32'h0;
        exp_pb_rdata = 32'h0;
        tick();
        i_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({o_bus_request, o_pa_ready, o_pb_ready} !== 3'b000) begin
                n_errors++;
                $display("FAIL midreset_idle: req=%b pa=%b pb=%b, expected 0 0 0", o_bus_request, o_pa_ready, o_pb_ready);
            end
        end
        n_checks++;
        if (bus_txn_count != base_txn) begin
            n_errors++;
            $display("FAIL midreset_abandon: txns=%0d, expected 0", bus_txn_count - base_txn);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_port_a_read();
        test_port_b_write();
        test_simultaneous();
        test_hold_after_ready();
        test_ready_outside_bus();
        test_random();
        test_reset_mid_bus_b();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
